// File: rtl/tap_controller_ir.sv
// IEEE 1149.1 TAP controller with instruction, bypass and IDCODE registers plus a
// one-hot select decoder for externally attached user data registers.
module tap_controller_ir #(
  parameter int          IR_WIDTH     = 4,
  parameter int          NUM_USER_DR  = 2,
  parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
  input  logic                   TCK,
  input  logic                   Reset,
  input  logic                   TMS,
  input  logic                   TDI,
  input  logic [NUM_USER_DR-1:0] UserTdo,
  output logic                   TDO,
  output logic                   TdoEn,
  output logic [3:0]             State,
  output logic [IR_WIDTH-1:0]    Instruction,
  output logic [NUM_USER_DR-1:0] DrSel,
  output logic                   CaptureDR,
  output logic                   ShiftDR,
  output logic                   UpdateDR,
  output logic                   TestLogicReset
);

  localparam logic [3:0] TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] SELECT_DR_SCAN   = 4'd2;
  localparam logic [3:0] CAPTURE_DR       = 4'd3;
  localparam logic [3:0] SHIFT_DR         = 4'd4;
  localparam logic [3:0] EXIT1_DR         = 4'd5;
  localparam logic [3:0] PAUSE_DR         = 4'd6;
  localparam logic [3:0] EXIT2_DR         = 4'd7;
  localparam logic [3:0] UPDATE_DR        = 4'd8;
  localparam logic [3:0] SELECT_IR_SCAN   = 4'd9;
  localparam logic [3:0] CAPTURE_IR       = 4'd10;
  localparam logic [3:0] SHIFT_IR         = 4'd11;
  localparam logic [3:0] EXIT1_IR         = 4'd12;
  localparam logic [3:0] PAUSE_IR         = 4'd13;
  localparam logic [3:0] EXIT2_IR         = 4'd14;
  localparam logic [3:0] UPDATE_IR        = 4'd15;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_ONES    = {IR_WIDTH{1'b1}};
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [3:0]             state_q,       state_d;
  logic [IR_WIDTH-1:0]    ir_shift_q,    ir_shift_d;
  logic [IR_WIDTH-1:0]    instruction_q, instruction_d;
  logic                   bypass_q,      bypass_d;
  logic [31:0]            idcode_q,      idcode_d;

  logic [NUM_USER_DR-1:0] dr_sel_s;
  logic                   is_idcode_s;
  logic                   is_user_s;
  logic                   is_bypass_s;
  logic                   tdo_s;

  always_comb begin
    state_d = TEST_LOGIC_RESET;
    case (state_q)
      TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Unassigned codes (including 0) fall back to BYPASS so a DR scan always has a path.
  always_comb begin
    dr_sel_s    = {NUM_USER_DR{1'b0}};
    is_idcode_s = 1'b0;
    if (instruction_q == IR_ONES) begin
      is_idcode_s = 1'b0;
    end else if (instruction_q == IR_IDCODE) begin
      is_idcode_s = 1'b1;
    end else begin
      for (int k = 0; k < NUM_USER_DR; k++) begin
        if (instruction_q == IR_WIDTH'(k + 2)) begin
          dr_sel_s[k] = 1'b1;
        end else begin
          dr_sel_s[k] = 1'b0;
        end
      end
    end
  end

  assign is_user_s   = |dr_sel_s;
  assign is_bypass_s = !is_idcode_s && !is_user_s;

  always_comb begin
    ir_shift_d = ir_shift_q;
    case (state_q)
      CAPTURE_IR: ir_shift_d = IR_CAPTURE;
      SHIFT_IR:   ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      default:    ir_shift_d = ir_shift_q;
    endcase
  end

  // Looking at the next state lets Instruction already read IDCODE on TMS-reset entry.
  always_comb begin
    instruction_d = instruction_q;
    if (state_d == TEST_LOGIC_RESET) begin
      instruction_d = IR_IDCODE;
    end else if (state_q == UPDATE_IR) begin
      instruction_d = ir_shift_q;
    end else begin
      instruction_d = instruction_q;
    end
  end

  always_comb begin
    bypass_d = bypass_q;
    idcode_d = idcode_q;
    case (state_q)
      CAPTURE_DR: begin
        bypass_d = 1'b0;
        if (is_idcode_s) begin
          idcode_d = IDCODE_VALUE;
        end else begin
          idcode_d = idcode_q;
        end
      end
      SHIFT_DR: begin
        if (is_bypass_s) begin
          bypass_d = TDI;
        end else begin
          bypass_d = bypass_q;
        end
        if (is_idcode_s) begin
          idcode_d = {TDI, idcode_q[31:1]};
        end else begin
          idcode_d = idcode_q;
        end
      end
      default: begin
        bypass_d = bypass_q;
        idcode_d = idcode_q;
      end
    endcase
  end

  always_comb begin
    tdo_s = 1'b0;
    case (state_q)
      SHIFT_IR: tdo_s = ir_shift_q[0];
      SHIFT_DR: begin
        if (is_idcode_s) begin
          tdo_s = idcode_q[0];
        end else if (is_user_s) begin
          tdo_s = |(UserTdo & dr_sel_s);
        end else begin
          tdo_s = bypass_q;
        end
      end
      default:  tdo_s = 1'b0;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (Reset) begin
      state_q       <= TEST_LOGIC_RESET;
      ir_shift_q    <= IR_CAPTURE;
      instruction_q <= IR_IDCODE;
      bypass_q      <= 1'b0;
      idcode_q      <= IDCODE_VALUE;
    end else begin
      state_q       <= state_d;
      ir_shift_q    <= ir_shift_d;
      instruction_q <= instruction_d;
      bypass_q      <= bypass_d;
      idcode_q      <= idcode_d;
    end
  end

  assign State          = state_q;
  assign Instruction    = instruction_q;
  assign DrSel          = dr_sel_s;
  assign TDO            = tdo_s;
  assign TdoEn          = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
  assign CaptureDR      = (state_q == CAPTURE_DR);
  assign ShiftDR        = (state_q == SHIFT_DR);
  assign UpdateDR       = (state_q == UPDATE_DR);
  assign TestLogicReset = (state_q == TEST_LOGIC_RESET);

endmodule

// File: tb/tb_tap_controller_ir.sv
// Bench for tap_controller_ir: directed test-plan steps followed by a random TMS/TDI walk,
// all checked against a queue-based scan model of the TAP.
module tb_tap_controller_ir;

  localparam int          IR_W   = 4;
  localparam int          NUM    = 2;
  localparam logic [31:0] IDCODE = 32'h1234_5671;

  logic            tck = 1'b0;
  logic            rst = 1'b0;
  logic            tms = 1'b0;
  logic            tdi = 1'b0;
  logic [NUM-1:0]  user_tdo = 2'b00;
  logic            tdo, tdo_en, cap_dr, sh_dr, upd_dr, tlr;
  logic [3:0]      state;
  logic [IR_W-1:0] instr;
  logic [NUM-1:0]  dr_sel;

  tap_controller_ir #(.IR_WIDTH(IR_W), .NUM_USER_DR(NUM), .IDCODE_VALUE(IDCODE)) dut (
    .TCK(tck), .Reset(rst), .TMS(tms), .TDI(tdi), .UserTdo(user_tdo),
    .TDO(tdo), .TdoEn(tdo_en), .State(state), .Instruction(instr), .DrSel(dr_sel),
    .CaptureDR(cap_dr), .ShiftDR(sh_dr), .UpdateDR(upd_dr), .TestLogicReset(tlr)
  );

  always #5 tck = ~tck;

  int vectors = 0;
  int miscompares = 0;
  logic tdo_seen;

  // Reference model: TMS transition table plus capture/shift queues (index 0 = next bit out).
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int         m_st = 0;
  logic [3:0] m_inst = 4'h1;
  bit         m_valid = 1'b0;
  bit         irq [$];
  bit         drq [$];

  // -1 = bypass, -2 = idcode, k >= 0 = user register k
  function automatic int m_kind(input logic [3:0] inst);
    int v;
    v = int'(inst);
    if (v == (1 << IR_W) - 1) return -1;
    if (v == 1) return -2;
    if (v >= 2 && v - 2 < NUM) return v - 2;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int kind;
    logic exp_tdo;
    logic [1:0] exp_sel;
    kind = m_kind(m_inst);
    exp_sel = (kind >= 0) ? 2'(1 << kind) : 2'b00;
    exp_tdo = 1'b0;
    if (m_st == 11) exp_tdo = irq[0];
    else if (m_st == 4) exp_tdo = (kind >= 0) ? user_tdo[kind] : drq[0];
    chk("state",       32'(state),  32'(m_st));
    chk("instruction", 32'(instr),  32'(m_inst));
    chk("drsel",       32'(dr_sel), 32'(exp_sel));
    chk("tdo",         32'(tdo),    32'(exp_tdo));
    chk("tdo_en",      32'(tdo_en), 32'(m_st == 4 || m_st == 11));
    chk("capture_dr",  32'(cap_dr), 32'(m_st == 3));
    chk("shift_dr",    32'(sh_dr),  32'(m_st == 4));
    chk("update_dr",   32'(upd_dr), 32'(m_st == 8));
    chk("tlr",         32'(tlr),    32'(m_st == 0));
  endtask

  task automatic model_edge(input logic r, input logic t, input logic d);
    int kind;
    logic [31:0] idv;
    idv = IDCODE;
    if (r) begin
      m_st = 0; m_inst = 4'h1; m_valid = 1'b1;
      irq.delete(); drq.delete();
    end else if (m_valid) begin
      kind = m_kind(m_inst);
      if (m_st == 10) begin
        irq.delete(); irq.push_back(1'b1);
        repeat (IR_W - 1) irq.push_back(1'b0);
      end else if (m_st == 11) begin
        void'(irq.pop_front()); irq.push_back(d);
      end else if (m_st == 15) begin
        for (int i = 0; i < IR_W; i++) m_inst[i] = irq[i];
      end
      if (m_st == 3) begin
        drq.delete();
        if (kind == -2) for (int i = 0; i < 32; i++) drq.push_back(idv[i]);
        else drq.push_back(1'b0);
      end else if (m_st == 4 && kind < 0) begin
        void'(drq.pop_front()); drq.push_back(d);
      end
      m_st = t ? nx1[m_st] : nx0[m_st];
      if (m_st == 0) m_inst = 4'h1;
    end
  endtask

  // One TCK cycle: drive at negedge, check, clock, advance model.
  task automatic step(input logic r, input logic t, input logic d);
    rst = r; tms = t; tdi = d; user_tdo = 2'($urandom);
    #1;
    if (m_valid) check_all();
    tdo_seen = tdo;
    @(posedge tck);
    model_edge(r, t, d);
    @(negedge tck);
  endtask

  task automatic walk(input logic [15:0] tms_bits, input int n);
    for (int i = 0; i < n; i++) step(1'b0, tms_bits[i], 1'b0);
  endtask

  task automatic shift_bits(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = 32'h0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, (i == n - 1), din[i]);
      dout[i] = tdo_seen;
    end
  endtask

  task automatic load_ir(input logic [3:0] val);
    logic [31:0] w;
    walk(16'h0003, 4);
    shift_bits(32'(val), IR_W, w);
    walk(16'h0001, 2);
  endtask

  initial begin
    logic [31:0] w;
    int r, t;

    step(1'b1, 1'b0, 1'b0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_inst",  32'(instr), 32'h1);
    chk("rst_tlr",   32'(tlr),   32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("rti_state", 32'(state), 32'h1);

    walk(16'h0001, 3);
    shift_bits(32'h0, 32, w);
    chk("idcode_read", w, 32'h1234_5671);
    walk(16'h0001, 2);

    walk(16'h0003, 4);
    shift_bits(32'hF, IR_W, w);
    chk("ir_capture", w, 32'h1);
    walk(16'h0001, 2);
    chk("inst_all_ones", 32'(instr), 32'hF);
    walk(16'h0001, 3);
    shift_bits(32'h0D, 5, w);
    chk("bypass_seq", w, 32'h1A);
    walk(16'h0001, 2);

    load_ir(4'h3);
    chk("drsel_user1", 32'(dr_sel), 32'h2);
    walk(16'h0001, 3);
    user_tdo = 2'b01; #1;
    chk("user0_ignored", 32'(tdo), 32'h0);
    user_tdo = 2'b10; #1;
    chk("user1_tdo", 32'(tdo), 32'h1);
    repeat (6) step(1'b0, 1'b0, 1'($urandom));
    step(1'b0, 1'b1, 1'b0);
    walk(16'h0001, 2);

    load_ir(4'h0);
    chk("drsel_zero", 32'(dr_sel), 32'h0);
    walk(16'h0001, 3);
    shift_bits(32'h13, 5, w);
    chk("bypass_inst0", w, 32'h06);
    walk(16'h0001, 2);

    walk(16'h0001, 3);
    walk(16'h000F, 4);
    chk("esc4_state", 32'(state), 32'h9);
    walk(16'h0001, 1);
    chk("esc5_state", 32'(state), 32'h0);
    chk("esc5_inst",  32'(instr), 32'h1);

    walk(16'h0006, 5);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    walk(16'h0001, 2);
    chk("pause_inst",  32'(instr),  32'h2);
    chk("pause_drsel", 32'(dr_sel), 32'h1);

    walk(16'h0003, 4);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_inst",  32'(instr), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0) ? 1 : 0;
      t = ($urandom_range(0, 9) < 4) ? 1 : 0;
      step(1'(r), 1'(t), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
